// File: rtl/striping_pkg.sv
// ---------------------------------------------------------------------------
// striping_pkg
//   Definitions shared by the transmit-side lane distributor (striping) and
//   the receive-side recombiner (un_striping).
//   - DATA_W_DEF : default word / lane width
//   - CNT_W_DEF  : default per-lane word counter width
//   - lane_phase_e : slot phase encoding (LANE0 = 0, LANE1 = 1)
//   - IDLE_WORD  : value driven on a lane during an idle (invalid) slot
// ---------------------------------------------------------------------------
package striping_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_phase_e;

  localparam logic [DATA_W_DEF-1:0] IDLE_WORD = '0;

endpackage : striping_pkg

// File: rtl/stripe_lane_reg.sv
// ---------------------------------------------------------------------------
// stripe_lane_reg
//   Output register for one lane of the striping distributor. On its slot it
//   loads the incoming word and valid, or the idle word with valid low when
//   the slot is empty; between slots it holds.
//   Optional feature macro: STRIPING_WORD_CNT_EN adds a wrapping count of the
//   valid words written to this lane.
// Ports
//   clk_i      in   1       clock (clk_2f domain)
//   rst_ni     in   1       asynchronous active-low reset
//   slot_en_i  in   1       this lane owns the current slot
//   valid_i    in   1       incoming word qualifier
//   data_i     in   DATA_W  incoming word
//   data_o     out  DATA_W  registered lane word
//   valid_o    out  1       registered lane qualifier
//   cnt_o      out  CNT_W   valid words sent (STRIPING_WORD_CNT_EN only)
// ---------------------------------------------------------------------------
module stripe_lane_reg
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STRIPING_WORD_CNT_EN
  ,parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              slot_en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
`ifdef STRIPING_WORD_CNT_EN
  ,output logic [CNT_W-1:0] cnt_o
`endif
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= DATA_W'(IDLE_WORD);
      valid_q <= 1'b0;
    end else if (slot_en_i) begin
      // The idle word is forced on an empty slot so that whatever sits on
      // data_i (including X) never leaks onto the lane.
      data_q  <= valid_i ? data_i : DATA_W'(IDLE_WORD);
      valid_q <= valid_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef STRIPING_WORD_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Wraps modulo 2^CNT_W by design; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (slot_en_i && valid_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule : stripe_lane_reg

// File: rtl/striping.sv
// ---------------------------------------------------------------------------
// striping
//   Transmit-side lane distributor. Words arriving at clk_2f rate are sent
//   round-robin to lane_0 and lane_1, so each lane updates at clk_f rate.
//   The slot phase toggles on every edge out of reset regardless of
//   valid_in, keeping lane timing locked to clk_f; gaps become idle slots.
//   Optional feature macro: STRIPING_WORD_CNT_EN exposes per-lane valid word
//   counters cnt_0 / cnt_1.
// Ports
//   clk_2f    in   1       single clock
//   reset     in   1       asynchronous active-low reset
//   data_in   in   DATA_W  input word
//   valid_in  in   1       data_in qualifier
//   lane_0    out  DATA_W  lane 0 word (registered)
//   valid_0   out  1       lane 0 qualifier (registered)
//   lane_1    out  DATA_W  lane 1 word (registered)
//   valid_1   out  1       lane 1 qualifier (registered)
//   sel       out  1       phase of the next slot: 0 = lane 0, 1 = lane 1
//   cnt_0     out  CNT_W   valid words on lane 0 (STRIPING_WORD_CNT_EN only)
//   cnt_1     out  CNT_W   valid words on lane 1 (STRIPING_WORD_CNT_EN only)
// ---------------------------------------------------------------------------
module striping
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STRIPING_WORD_CNT_EN
  ,parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic              sel
`ifdef STRIPING_WORD_CNT_EN
  ,output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0]  cnt_1
`endif
);

  lane_phase_e state_q, state_d;
  logic        slot_en_0, slot_en_1;

  // Reset returns to LANE0 whatever phase it interrupted, so the first edge
  // after release is always a lane 0 slot.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q <= LANE0;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is assigned before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = (state_q == LANE0) ? LANE1 : LANE0;
    slot_en_0 = (state_q == LANE0);
    slot_en_1 = (state_q == LANE1);
  end

  assign sel = state_q;

  stripe_lane_reg #(
    .DATA_W (DATA_W)
`ifdef STRIPING_WORD_CNT_EN
    ,.CNT_W (CNT_W)
`endif
  ) u_lane_0 (
    .clk_i     (clk_2f),
    .rst_ni    (reset),
    .slot_en_i (slot_en_0),
    .valid_i   (valid_in),
    .data_i    (data_in),
    .data_o    (lane_0),
    .valid_o   (valid_0)
`ifdef STRIPING_WORD_CNT_EN
    ,.cnt_o    (cnt_0)
`endif
  );

  stripe_lane_reg #(
    .DATA_W (DATA_W)
`ifdef STRIPING_WORD_CNT_EN
    ,.CNT_W (CNT_W)
`endif
  ) u_lane_1 (
    .clk_i     (clk_2f),
    .rst_ni    (reset),
    .slot_en_i (slot_en_1),
    .valid_i   (valid_in),
    .data_i    (data_in),
    .data_o    (lane_1),
    .valid_o   (valid_1)
`ifdef STRIPING_WORD_CNT_EN
    ,.cnt_o    (cnt_1)
`endif
  );

endmodule : striping

// File: tb/tb_striping.sv
// ---------------------------------------------------------------------------
// tb_striping
//   Directed self-checking bench for the striping lane distributor.
//   A small expectation model tracks the slot phase and both lanes; the
//   random loopback section recombines the lanes the way un_striping does
//   and compares the recovered order against the words sent.
//   With STRIPING_WORD_CNT_EN defined the DUT is built with CNT_W = 4 and the
//   counter wrap is checked.
// ---------------------------------------------------------------------------
module tb_striping;
  import striping_pkg::*;

  localparam int DW = DATA_W_DEF;
`ifdef STRIPING_WORD_CNT_EN
  localparam int CW = 4;
`endif

  logic          clk_2f = 1'b0;
  logic          reset  = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] lane_0, lane_1;
  logic          valid_0, valid_1, sel;
`ifdef STRIPING_WORD_CNT_EN
  logic [CW-1:0] cnt_0, cnt_1;
`endif

  striping #(
    .DATA_W (DW)
`ifdef STRIPING_WORD_CNT_EN
    ,.CNT_W (CW)
`endif
  ) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .lane_0   (lane_0),
    .valid_0  (valid_0),
    .lane_1   (lane_1),
    .valid_1  (valid_1),
    .sel      (sel)
`ifdef STRIPING_WORD_CNT_EN
    ,.cnt_0   (cnt_0),
    .cnt_1    (cnt_1)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int n_vec = 0;
  int n_err = 0;

  // Expectation model
  logic [DW-1:0] m_l0 = '0, m_l1 = '0;
  logic          m_v0 = 1'b0, m_v1 = 1'b0, m_ph = 1'b0;

  // Loopback bookkeeping
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  bit            collect = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/lane_0"},  lane_0,       m_l0);
    check({tag, "/valid_0"}, DW'(valid_0), DW'(m_v0));
    check({tag, "/lane_1"},  lane_1,       m_l1);
    check({tag, "/valid_1"}, DW'(valid_1), DW'(m_v1));
    check({tag, "/sel"},     DW'(sel),     DW'(m_ph));
  endtask

  task automatic model_reset();
    m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_ph = 1'b0;
  endtask

  // One clk_2f slot: drive on the falling edge (also keeps reset released),
  // update the model at the rising edge, check 1 time unit later.
  task automatic slot(input string tag, input logic v, input logic [DW-1:0] d);
    @(negedge clk_2f);
    reset    = 1'b1;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    if (m_ph == 1'b0) begin
      m_l0 = v ? d : '0;
      m_v0 = v;
    end else begin
      m_l1 = v ? d : '0;
      m_v1 = v;
    end
    m_ph = ~m_ph;
    #1;
    check_all(tag);
    // A clk_f period closes after the lane 1 slot: read lane 0 then lane 1.
    if (collect && m_ph == 1'b0) begin
      if (valid_0) out_q.push_back(lane_0);
      if (valid_1) out_q.push_back(lane_1);
    end
  endtask

  initial begin
    // ---- 1: reset held 3 cycles with active-looking inputs ----
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    model_reset();
    repeat (3) begin
      @(posedge clk_2f);
      #1;
      check_all("t1_reset");
    end

    // ---- 2: back-to-back stream, alternate lanes, each held 2 cycles ----
    slot("t2_s0", 1'b1, 32'hAAAA_AAAA);
    check("t2_s0_lane0_A", lane_0, 32'hAAAA_AAAA);
    slot("t2_s1", 1'b1, 32'hBBBB_BBBB);
    check("t2_s1_lane0_hold", lane_0, 32'hAAAA_AAAA);
    check("t2_s1_lane1_B", lane_1, 32'hBBBB_BBBB);
    slot("t2_s2", 1'b1, 32'hCCCC_CCCC);
    check("t2_s2_lane0_C", lane_0, 32'hCCCC_CCCC);
    check("t2_s2_lane1_hold", lane_1, 32'hBBBB_BBBB);
    slot("t2_s3", 1'b1, 32'hDDDD_DDDD);
    check("t2_s3_lane1_D", lane_1, 32'hDDDD_DDDD);

    // ---- 3: gap pattern 1,0,1,1 with X on the idle slot ----
    slot("t3_s0", 1'b1, 32'h1);
    check("t3_s0_lane0", lane_0, 32'h1);
    slot("t3_s1", 1'b0, 'x);
    check("t3_s1_lane1_idle", lane_1, 32'h0);
    check("t3_s1_valid1_low", DW'(valid_1), DW'(1'b0));
    slot("t3_s2", 1'b1, 32'h3);
    check("t3_s2_lane0", lane_0, 32'h3);
    slot("t3_s3", 1'b1, 32'h4);
    check("t3_s3_lane1", lane_1, 32'h4);

    // ---- 4: async reset while sel = 1, restart on lane 0 ----
    slot("t4_pre", 1'b1, 32'h77);
    check("t4_sel_is_1", DW'(sel), DW'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t4_async_clear");
    slot("t4_restart", 1'b1, 32'h88);
    check("t4_restart_lane0", lane_0, 32'h88);
    check("t4_restart_lane1_zero", lane_1, 32'h0);

    // ---- 5: loopback, 64 random words with random gaps ----
    slot("t5_align", 1'b0, 32'h0);      // back to a clk_f period boundary
    collect = 1'b1;
    while (in_q.size() < 64) begin
      logic          v;
      logic [DW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (v) in_q.push_back(d);
      slot("t5_rand", v, d);
    end
    if (m_ph) slot("t5_pad", 1'b0, 32'h0);
    collect = 1'b0;
    check("t5_count", DW'(out_q.size()), DW'(in_q.size()));
    for (int i = 0; i < 64; i++) begin
      if (i < out_q.size())
        check($sformatf("t5_order[%0d]", i), out_q[i], in_q[i]);
    end

`ifdef STRIPING_WORD_CNT_EN
    // ---- 6: counter wrap with CNT_W = 4 ----
    @(negedge clk_2f);
    reset = 1'b0;
    #1;
    model_reset();
    check("t6_cnt0_reset", DW'(cnt_0), DW'(0));
    check("t6_cnt1_reset", DW'(cnt_1), DW'(0));
    for (int i = 0; i < 40; i++) begin
      slot("t6_stream", 1'b1, DW'(i + 1));
      if (i == 31) begin
        check("t6_cnt0_wrap16", DW'(cnt_0), DW'(0));
        check("t6_cnt1_wrap16", DW'(cnt_1), DW'(0));
      end
    end
    check("t6_cnt0_final", DW'(cnt_0), DW'(4));
    check("t6_cnt1_final", DW'(cnt_1), DW'(4));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_striping
